// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: head-aligned halfword instruction queue with RVC realignment, PC tracking and flush
module rv_fetch_queue #(
   parameter int                            IADDR_SPACE_BITS = 16,
   parameter int                            WIDTH            = 16,
   parameter int                            DEPTH_BITS       = 3,
   parameter int                            PUSH_WIDTH       = 2,
   parameter logic [IADDR_SPACE_BITS-1:0]   RESET_PC         = '0
) (
   input  logic                               i_clk,
   input  logic                               i_reset_n,
   input  logic                               i_flush,
   input  logic [IADDR_SPACE_BITS-2:0]        i_flush_pc,
   input  logic [PUSH_WIDTH*WIDTH-1:0]        i_push_data,
   input  logic [$clog2(PUSH_WIDTH+1)-1:0]    i_push_cnt,
   output logic                               o_push_ready,
   input  logic                               i_pop,
   output logic                               o_valid,
   output logic                               o_is_comp,
   output logic [WIDTH-1:0]                   o_data_lo,
   output logic [WIDTH-1:0]                   o_data_hi,
   output logic [IADDR_SPACE_BITS-2:0]        o_pc,
   output logic [DEPTH_BITS:0]                o_level
);
   localparam int QSIZE = 1 << DEPTH_BITS;
   localparam int LW    = DEPTH_BITS + 1;
   localparam int CW    = $clog2(PUSH_WIDTH + 1);
   localparam int PCW   = IADDR_SPACE_BITS - 1;
   logic [WIDTH-1:0] r_q [QSIZE];
   logic [WIDTH-1:0] w_q [QSIZE];
   logic [WIDTH-1:0] w_ext [QSIZE+2];
   logic [LW-1:0]    r_level;
   logic [LW-1:0]    w_popn;
   logic [LW-1:0]    w_pushn;
   logic [LW-1:0]    w_base;
   logic [PCW-1:0]   r_pc;
   logic             w_pop;
   logic             w_push;
   assign o_is_comp    = r_q[0][1:0] != 2'b11;
   assign o_data_lo    = r_q[0];
   assign o_data_hi    = r_q[1];
   assign o_valid      = (r_level >= LW'(2)) | ((r_level == LW'(1)) & o_is_comp);
   assign o_push_ready = r_level <= LW'(QSIZE - PUSH_WIDTH);
   assign o_pc         = r_pc;
   assign o_level      = r_level;
   assign w_pop        = i_pop & o_valid;
   assign w_push       = o_push_ready & (i_push_cnt != '0) & (i_push_cnt <= CW'(PUSH_WIDTH));
   assign w_popn       = w_pop ? (o_is_comp ? LW'(1) : LW'(2)) : '0;
   assign w_pushn      = w_push ? LW'(i_push_cnt) : '0;
   assign w_base       = r_level - w_popn;
   // shift out the popped instruction, then drop new halfwords just above the survivors
   always_comb begin
      for (int i = 0; i < QSIZE; i++) w_ext[i] = r_q[i];
      w_ext[QSIZE]   = '0;
      w_ext[QSIZE+1] = '0;
      for (int i = 0; i < QSIZE; i++)
         w_q[i] = (w_popn == LW'(2)) ? w_ext[i+2] : (w_popn == LW'(1)) ? w_ext[i+1] : w_ext[i];
      for (int i = 0; i < QSIZE; i++)
         for (int k = 0; k < PUSH_WIDTH; k++)
            if ((LW'(k) < w_pushn) && (w_base + LW'(k) == LW'(i))) w_q[i] = i_push_data[k*WIDTH +: WIDTH];
   end
   // queue, level and PC state; flush redirects and empties without touching entry contents
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_level <= '0;
         r_pc    <= RESET_PC[IADDR_SPACE_BITS-1:1];
         for (int i = 0; i < QSIZE; i++) r_q[i] <= '0;
      end else if (i_flush) begin
         r_level <= '0;
         r_pc    <= i_flush_pc;
      end else begin
         r_level <= w_base + w_pushn;
         r_pc    <= r_pc + PCW'(w_popn);
         r_q     <= w_q;
      end
   end
endmodule

// File: tb/tb_rv_fetch_queue.sv
// tb_rv_fetch_queue: directed vector table plus reset, throughput and async-reset sequences
module tb_rv_fetch_queue;
   logic        i_clk;
   logic        i_reset_n;
   logic        i_flush;
   logic [14:0] i_flush_pc;
   logic [31:0] i_push_data;
   logic [1:0]  i_push_cnt;
   logic        o_push_ready;
   logic        i_pop;
   logic        o_valid;
   logic        o_is_comp;
   logic [15:0] o_data_lo;
   logic [15:0] o_data_hi;
   logic [14:0] o_pc;
   logic [3:0]  o_level;
   int          n_checks;
   int          n_fail;

   typedef struct {
      logic        flush;
      logic [14:0] fpc;
      logic [31:0] pdata;
      logic [1:0]  cnt;
      logic        pop;
      logic [3:0]  level;
      logic        valid;
      logic        comp;
      logic        chk_lo;
      logic [15:0] lo;
      logic        chk_hi;
      logic [15:0] hi;
      logic [14:0] pc;
      logic        ready;
   } vec_t;

   vec_t vq[$];

   rv_fetch_queue #(
      .IADDR_SPACE_BITS(16),
      .WIDTH(16),
      .DEPTH_BITS(3),
      .PUSH_WIDTH(2),
      .RESET_PC(16'h0100)
   ) dut (
      .i_clk(i_clk),
      .i_reset_n(i_reset_n),
      .i_flush(i_flush),
      .i_flush_pc(i_flush_pc),
      .i_push_data(i_push_data),
      .i_push_cnt(i_push_cnt),
      .o_push_ready(o_push_ready),
      .i_pop(i_pop),
      .o_valid(o_valid),
      .o_is_comp(o_is_comp),
      .o_data_lo(o_data_lo),
      .o_data_hi(o_data_hi),
      .o_pc(o_pc),
      .o_level(o_level)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      i_flush     = 1'b0;
      i_flush_pc  = 15'h0;
      i_push_data = 32'h0;
      i_push_cnt  = 2'd0;
      i_pop       = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_level"}, 32'(o_level), 32'd0);
      chk({tag, "_valid"}, 32'(o_valid), 32'd0);
      chk({tag, "_pc"}, 32'(o_pc), 32'h0080);
      chk({tag, "_ready"}, 32'(o_push_ready), 32'd1);
      chk({tag, "_lo"}, 32'(o_data_lo), 32'd0);
      chk({tag, "_hi"}, 32'(o_data_hi), 32'd0);
      chk({tag, "_comp"}, 32'(o_is_comp), 32'd1);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      i_reset_n = 1'b1;
      idle();
      // flush fpc pdata cnt pop | level valid comp chk_lo lo chk_hi hi pc ready
      vq.push_back('{1'b0, 15'h0, 32'h0013_4501, 2'd2, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 16'h4501, 1'b0, 16'h0, 15'h0080, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 16'h0013, 1'b0, 16'h0, 15'h0081, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 16'h0013, 1'b0, 16'h0, 15'h0081, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0000_0000, 2'd1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0000, 15'h0081, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 15'h0083, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0000_0013, 2'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 16'h0013, 1'b0, 16'h0, 15'h0083, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h1103_0000, 2'd2, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0000, 15'h0083, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h4501_2222, 2'd2, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0000, 15'h0083, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0001_4502, 2'd2, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0000, 15'h0083, 1'b0});
      vq.push_back('{1'b0, 15'h0, 32'h7777_7777, 2'd2, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0000, 15'h0083, 1'b0});
      vq.push_back('{1'b0, 15'h0, 32'h7777_7777, 2'd1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0000, 15'h0083, 1'b0});
      vq.push_back('{1'b0, 15'h0, 32'h0, 2'd0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 16'h1103, 1'b1, 16'h2222, 15'h0085, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0000_0013, 2'd1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 16'h1103, 1'b1, 16'h2222, 15'h0085, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h4505_6666, 2'd2, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 16'h4501, 1'b0, 16'h0, 15'h0087, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0, 2'd0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 16'h4502, 1'b0, 16'h0, 15'h0088, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0, 2'd0, 1'b1, 4'd4, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0, 15'h0089, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0, 2'd0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h6666, 15'h008A, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0, 2'd0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 16'h4505, 1'b0, 16'h0, 15'h008C, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h1234_5678, 2'd3, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1, 16'h4505, 1'b0, 16'h0, 15'h008C, 1'b1});
      vq.push_back('{1'b1, 15'h1235, 32'h1234_5678, 2'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 15'h1235, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0000_4501, 2'd1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1, 16'h4501, 1'b0, 16'h0, 15'h1235, 1'b1});
      vq.push_back('{1'b1, 15'h7FFF, 32'h0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 15'h7FFF, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0000_0001, 2'd1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0, 15'h7FFF, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 15'h0000, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h4501_4501, 2'd2, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 16'h4501, 1'b0, 16'h0, 15'h0000, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h4501_4501, 2'd2, 1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 16'h4501, 1'b0, 16'h0, 15'h0000, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h4501_4501, 2'd2, 1'b0, 4'd6, 1'b1, 1'b1, 1'b1, 16'h4501, 1'b0, 16'h0, 15'h0000, 1'b1});
      vq.push_back('{1'b0, 15'h0, 32'h4501_4501, 2'd2, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 16'h4501, 1'b0, 16'h0, 15'h0000, 1'b0});
      vq.push_back('{1'b0, 15'h0, 32'h4501_4501, 2'd2, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 16'h4501, 1'b0, 16'h0, 15'h0001, 1'b0});
      #2 i_reset_n = 1'b0;
      #1 chk_reset("por");
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      for (int n = 0; n < vq.size(); n++) begin
         @(negedge i_clk);
         i_flush     = vq[n].flush;
         i_flush_pc  = vq[n].fpc;
         i_push_data = vq[n].pdata;
         i_push_cnt  = vq[n].cnt;
         i_pop       = vq[n].pop;
         @(posedge i_clk);
         #1;
         chk($sformatf("v%0d_level", n), 32'(o_level), 32'(vq[n].level));
         chk($sformatf("v%0d_valid", n), 32'(o_valid), 32'(vq[n].valid));
         chk($sformatf("v%0d_pc", n), 32'(o_pc), 32'(vq[n].pc));
         chk($sformatf("v%0d_ready", n), 32'(o_push_ready), 32'(vq[n].ready));
         if (vq[n].chk_lo) begin
            chk($sformatf("v%0d_lo", n), 32'(o_data_lo), 32'(vq[n].lo));
            chk($sformatf("v%0d_comp", n), 32'(o_is_comp), 32'(vq[n].comp));
         end
         if (vq[n].chk_hi) chk($sformatf("v%0d_hi", n), 32'(o_data_hi), 32'(vq[n].hi));
      end
      @(negedge i_clk);
      idle();
      i_flush    = 1'b1;
      i_flush_pc = 15'h0010;
      @(posedge i_clk);
      #1 chk("tp_flush_pc", 32'(o_pc), 32'h0010);
      @(negedge i_clk);
      idle();
      i_push_data = 32'h4501_4501;
      i_push_cnt  = 2'd2;
      @(posedge i_clk);
      #1 chk("tp_fill_level", 32'(o_level), 32'd2);
      for (int n = 0; n < 6; n++) begin
         @(negedge i_clk);
         i_push_data = 32'h0000_4501;
         i_push_cnt  = 2'd1;
         i_pop       = 1'b1;
         @(posedge i_clk);
         #1;
         chk($sformatf("tp%0d_level", n), 32'(o_level), 32'd2);
         chk($sformatf("tp%0d_valid", n), 32'(o_valid), 32'd1);
         chk($sformatf("tp%0d_pc", n), 32'(o_pc), 32'h0010 + 32'(n) + 32'd1);
      end
      @(negedge i_clk);
      idle();
      #2 i_reset_n = 1'b0;
      #1 chk_reset("arst");
      @(negedge i_clk);
      i_reset_n = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
